// File: rtl/video_timing_gen_if.sv
// Raster timing interface: pixel-rate outputs from the timing generator plus
// the host/IRQ control inputs it consumes.
interface video_timing_gen_if #(
  parameter int unsigned P_count_bits = 16
);
  logic                    O_clock;
  logic                    O_rise;
  logic [P_count_bits-1:0] O_hcount;
  logic [P_count_bits-1:0] O_vcount;
  logic                    O_not_hblank;
  logic                    O_not_vblank;
  logic                    O_not_blank;
  logic                    O_hsync;
  logic                    O_vsync;
  logic                    O_line_start;
  logic                    O_frame_start;
  logic                    O_vblank_flag;
  logic                    O_nmi;
  logic                    O_irq;
  logic                    I_nmi_enable;
  logic                    I_status_read;
  logic [P_count_bits-1:0] I_irq_line;

  modport master (
    output O_clock, O_rise, O_hcount, O_vcount, O_not_hblank, O_not_vblank,
           O_not_blank, O_hsync, O_vsync, O_line_start, O_frame_start,
           O_vblank_flag, O_nmi, O_irq,
    input  I_nmi_enable, I_status_read, I_irq_line
  );

  modport slave (
    input  O_clock, O_rise, O_hcount, O_vcount, O_not_hblank, O_not_vblank,
           O_not_blank, O_hsync, O_vsync, O_line_start, O_frame_start,
           O_vblank_flag, O_nmi, O_irq,
    output I_nmi_enable, I_status_read, I_irq_line
  );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel divider, h/v counters, blanking,
// syncs, vblank status flag with read-clear, level NMI.
// Optional raster-line IRQ compare is built only when RASTER_IRQ_EN is defined.
module video_timing_gen #(
  parameter int unsigned P_clock_div  = 4,
  parameter int unsigned P_count_bits = 16,
  parameter int unsigned P_h_active   = 256,
  parameter int unsigned P_h_front    = 11,
  parameter int unsigned P_h_sync     = 25,
  parameter int unsigned P_h_back     = 49,
  parameter int unsigned P_v_active   = 240,
  parameter int unsigned P_v_front    = 1,
  parameter int unsigned P_v_sync     = 3,
  parameter int unsigned P_v_back     = 18,
  parameter int unsigned P_hsync_pol  = 0,
  parameter int unsigned P_vsync_pol  = 0
) (
  input  logic               I_clock,
  input  logic               I_reset,
  video_timing_gen_if.master bus
);

  localparam int unsigned CW          = P_count_bits;
  localparam int unsigned DW          = (P_clock_div > 2) ? $clog2(P_clock_div) : 1;
  localparam int unsigned LP_h_total  = P_h_active + P_h_front + P_h_sync + P_h_back;
  localparam int unsigned LP_v_total  = P_v_active + P_v_front + P_v_sync + P_v_back;
  localparam int unsigned LP_hs_start = P_h_active + P_h_front;
  localparam int unsigned LP_hs_end   = LP_hs_start + P_h_sync;
  localparam int unsigned LP_vs_start = P_v_active + P_v_front;
  localparam int unsigned LP_vs_end   = LP_vs_start + P_v_sync;
  localparam logic        LP_hpol     = 1'(P_hsync_pol);
  localparam logic        LP_vpol     = 1'(P_vsync_pol);

  localparam logic [DW-1:0] LP_div_last = DW'(P_clock_div - 1);
  localparam logic [DW-1:0] LP_div_half = DW'(P_clock_div / 2);
  localparam logic [CW-1:0] LP_h_last   = CW'(LP_h_total - 1);
  localparam logic [CW-1:0] LP_v_last   = CW'(LP_v_total - 1);
  localparam logic [CW-1:0] LP_vflag_on = CW'(P_v_active + 1);

  localparam bit LP_params_ok = (P_clock_div >= 2) && ((P_clock_div % 2) == 0) &&
                                (64'(LP_h_total) <= (64'd1 << P_count_bits)) &&
                                (64'(LP_v_total) <= (64'd1 << P_count_bits));

  logic [DW-1:0] div_q, div_d;
  logic          clock_q, clock_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] hcount_q, hcount_d;
  logic [CW-1:0] vcount_q, vcount_d;
  logic [CW-1:0] h_next, v_next;
  logic          not_hblank_q, not_hblank_d;
  logic          not_vblank_q, not_vblank_d;
  logic          not_blank_q, not_blank_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          vblank_flag_q, vblank_flag_d;
  logic          nmi_q, nmi_d;

  // Pixel divider; strobe and divided clock are decoded from the next count.
  always_comb begin
    div_d   = (div_q == LP_div_last) ? '0 : div_q + DW'(1);
    rise_d  = (div_d == LP_div_last);
    clock_d = (div_d < LP_div_half);
  end

  // Raster counters and the outputs decoded from the post-advance position.
  always_comb begin
    h_next = (hcount_q == LP_h_last) ? '0 : hcount_q + CW'(1);
    v_next = vcount_q;
    if (hcount_q == LP_h_last) begin
      v_next = (vcount_q == LP_v_last) ? '0 : vcount_q + CW'(1);
    end

    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    not_hblank_d  = not_hblank_q;
    not_vblank_d  = not_vblank_q;
    not_blank_d   = not_blank_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;

    if (rise_q) begin
      hcount_d      = h_next;
      vcount_d      = v_next;
      not_hblank_d  = (h_next < CW'(P_h_active));
      not_vblank_d  = (v_next < CW'(P_v_active));
      not_blank_d   = (h_next < CW'(P_h_active)) && (v_next < CW'(P_v_active));
      hsync_d       = ((h_next >= CW'(LP_hs_start)) && (h_next < CW'(LP_hs_end))) ? LP_hpol : ~LP_hpol;
      vsync_d       = ((v_next >= CW'(LP_vs_start)) && (v_next < CW'(LP_vs_end))) ? LP_vpol : ~LP_vpol;
      line_start_d  = (h_next == '0);
      frame_start_d = (h_next == '0) && (v_next == '0);
    end
  end

  // Vblank status flag; a host read on the set edge wins so that frame sees no flag.
  always_comb begin
    vblank_flag_d = vblank_flag_q;
    if (rise_q && (h_next == CW'(1))) begin
      if (v_next == LP_vflag_on) begin
        vblank_flag_d = 1'b1;
      end else if (v_next == LP_v_last) begin
        vblank_flag_d = 1'b0;
      end
    end
    if (bus.I_status_read) begin
      vblank_flag_d = 1'b0;
    end
    nmi_d = vblank_flag_q & bus.I_nmi_enable;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      div_q         <= '0;
      clock_q       <= 1'b1;
      rise_q        <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      not_hblank_q  <= 1'b1;
      not_vblank_q  <= 1'b1;
      not_blank_q   <= 1'b1;
      hsync_q       <= ~LP_hpol;
      vsync_q       <= ~LP_vpol;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      vblank_flag_q <= 1'b0;
      nmi_q         <= 1'b0;
    end else begin
      div_q         <= div_d;
      clock_q       <= clock_d;
      rise_q        <= rise_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      not_hblank_q  <= not_hblank_d;
      not_vblank_q  <= not_vblank_d;
      not_blank_q   <= not_blank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      vblank_flag_q <= vblank_flag_d;
      nmi_q         <= nmi_d;
    end
  end

`ifdef RASTER_IRQ_EN
  logic irq_q, irq_d;

  // Raster IRQ: one pixel period on the advance into (P_h_active, I_irq_line).
  always_comb begin
    irq_d = irq_q;
    if (rise_q) begin
      irq_d = (h_next == CW'(P_h_active)) && (v_next == bus.I_irq_line);
    end
  end

  // Raster IRQ register.
  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign bus.O_irq = irq_q;
`else
  logic unused_irq_line;
  assign unused_irq_line = ^bus.I_irq_line;
  assign bus.O_irq       = 1'b0;
`endif

  // Flags an illegal parameter set while simulating.
  always_ff @(posedge I_clock) begin
    assert (LP_params_ok)
      else $error("video_timing_gen: illegal parameters (P_clock_div=%0d)", P_clock_div);
  end

  assign bus.O_clock       = clock_q;
  assign bus.O_rise        = rise_q;
  assign bus.O_hcount      = hcount_q;
  assign bus.O_vcount      = vcount_q;
  assign bus.O_not_hblank  = not_hblank_q;
  assign bus.O_not_vblank  = not_vblank_q;
  assign bus.O_not_blank   = not_blank_q;
  assign bus.O_hsync       = hsync_q;
  assign bus.O_vsync       = vsync_q;
  assign bus.O_line_start  = line_start_q;
  assign bus.O_frame_start = frame_start_q;
  assign bus.O_vblank_flag = vblank_flag_q;
  assign bus.O_nmi         = nmi_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default-parameter instance and a small-raster
// instance, each checked every cycle against a closed-form timing model through
// an expectation queue, plus directed checks of vblank/NMI, race, frame period,
// mid-frame reset and the optional raster IRQ.
module tb_video_timing_gen;

  typedef struct packed {
    int unsigned d, ha, hf, hs, hb, va, vf, vs, vb, hpol, vpol;
  } cfg_t;

  typedef struct packed {
    logic        clk, rise;
    logic [31:0] h, v;
    logic        nh, nv, nb, hs, vs, ls, fs, flag, nmi, irq;
  } exp_t;

  localparam int unsigned S_D = 2, S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 3;
  localparam int unsigned S_VA = 4, S_VF = 1, S_VS = 1, S_VB = 2, S_HPOL = 1, S_VPOL = 0;

  localparam cfg_t CFG_D = '{d:4, ha:256, hf:11, hs:25, hb:49, va:240, vf:1, vs:3, vb:18, hpol:0, vpol:0};
  localparam cfg_t CFG_S = '{d:S_D, ha:S_HA, hf:S_HF, hs:S_HS, hb:S_HB, va:S_VA, vf:S_VF, vs:S_VS, vb:S_VB, hpol:S_HPOL, vpol:S_VPOL};

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t q_d[$];
  exp_t q_s[$];

  video_timing_gen_if #(.P_count_bits(16)) d_if ();
  video_timing_gen_if #(.P_count_bits(8))  s_if ();

  video_timing_gen u_dut_d (
    .I_clock (clk),
    .I_reset (rst),
    .bus     (d_if)
  );

  video_timing_gen #(
    .P_clock_div (S_D),  .P_count_bits (8),
    .P_h_active  (S_HA), .P_h_front (S_HF), .P_h_sync (S_HS), .P_h_back (S_HB),
    .P_v_active  (S_VA), .P_v_front (S_VF), .P_v_sync (S_VS), .P_v_back (S_VB),
    .P_hsync_pol (S_HPOL), .P_vsync_pol (S_VPOL)
  ) u_dut_s (
    .I_clock (clk),
    .I_reset (rst),
    .bus     (s_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
  endtask

  // Expected outputs after n active edges since reset release.
  function automatic exp_t model(input cfg_t c, input int unsigned n, input exp_t prev,
                                 input logic rd, input logic en, input int unsigned line);
    exp_t        e;
    int unsigned ht, vt, m, p, h, v;
    logic        adv;
    ht  = c.ha + c.hf + c.hs + c.hb;
    vt  = c.va + c.vf + c.vs + c.vb;
    m   = n % c.d;
    p   = n / c.d;
    h   = p % ht;
    v   = (p / ht) % vt;
    adv = (n > 0) && (m == 0);
    e      = '0;
    e.clk  = (m < c.d / 2);
    e.rise = (m == c.d - 1);
    e.h    = h;
    e.v    = v;
    e.nh   = (h < c.ha);
    e.nv   = (v < c.va);
    e.nb   = e.nh && e.nv;
    e.hs   = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? 1'(c.hpol) : ~1'(c.hpol);
    e.vs   = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? 1'(c.vpol) : ~1'(c.vpol);
    e.ls   = (p > 0) && (h == 0);
    e.fs   = e.ls && (v == 0);
    e.flag = prev.flag;
    if (adv && h == 1 && v == c.va + 1) e.flag = 1'b1;
    else if (adv && h == 1 && v == vt - 1) e.flag = 1'b0;
    if (rd) e.flag = 1'b0;
    e.nmi  = prev.flag & en;
`ifdef RASTER_IRQ_EN
    e.irq  = adv ? ((h == c.ha) && (v == line)) : prev.irq;
`else
    e.irq  = 1'b0;
    if (line == 32'hFFFF_FFFF) e.irq = 1'b0;
`endif
    return e;
  endfunction

  task automatic cmp_rec(input string nm, input exp_t o, input exp_t e);
    chk({nm, ".clock"},       64'(o.clk),  64'(e.clk));
    chk({nm, ".rise"},        64'(o.rise), 64'(e.rise));
    chk({nm, ".hcount"},      64'(o.h),    64'(e.h));
    chk({nm, ".vcount"},      64'(o.v),    64'(e.v));
    chk({nm, ".not_hblank"},  64'(o.nh),   64'(e.nh));
    chk({nm, ".not_vblank"},  64'(o.nv),   64'(e.nv));
    chk({nm, ".not_blank"},   64'(o.nb),   64'(e.nb));
    chk({nm, ".hsync"},       64'(o.hs),   64'(e.hs));
    chk({nm, ".vsync"},       64'(o.vs),   64'(e.vs));
    chk({nm, ".line_start"},  64'(o.ls),   64'(e.ls));
    chk({nm, ".frame_start"}, 64'(o.fs),   64'(e.fs));
    chk({nm, ".vblank_flag"}, 64'(o.flag), 64'(e.flag));
    chk({nm, ".nmi"},         64'(o.nmi),  64'(e.nmi));
    chk({nm, ".irq"},         64'(o.irq),  64'(e.irq));
  endtask

  // Scoreboard producer: push the expected post-edge state at every active edge.
  initial begin
    int unsigned n_d, n_s;
    exp_t        st_d, st_s, z;
    n_d = 0; n_s = 0; z = '0; st_d = '0; st_s = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        n_d  = 0;
        n_s  = 0;
        st_d = model(CFG_D, 0, z, 1'b0, 1'b0, 0);
        st_s = model(CFG_S, 0, z, 1'b0, 1'b0, 0);
      end else begin
        n_d++;
        n_s++;
        st_d = model(CFG_D, n_d, st_d, d_if.I_status_read, d_if.I_nmi_enable, 32'(d_if.I_irq_line));
        st_s = model(CFG_S, n_s, st_s, s_if.I_status_read, s_if.I_nmi_enable, 32'(s_if.I_irq_line));
      end
      q_d.push_back(st_d);
      q_s.push_back(st_s);
    end
  end

  // Scoreboard consumer: compare DUT outputs against the queued expectation mid-cycle.
  initial begin
    exp_t o, e;
    forever begin
      @(negedge clk);
      if (q_d.size() > 0) begin
        e = q_d.pop_front();
        o = '0;
        o.clk = d_if.O_clock;  o.rise = d_if.O_rise;
        o.h = 32'(d_if.O_hcount); o.v = 32'(d_if.O_vcount);
        o.nh = d_if.O_not_hblank; o.nv = d_if.O_not_vblank; o.nb = d_if.O_not_blank;
        o.hs = d_if.O_hsync; o.vs = d_if.O_vsync;
        o.ls = d_if.O_line_start; o.fs = d_if.O_frame_start;
        o.flag = d_if.O_vblank_flag; o.nmi = d_if.O_nmi; o.irq = d_if.O_irq;
        cmp_rec("d", o, e);
      end
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        o = '0;
        o.clk = s_if.O_clock;  o.rise = s_if.O_rise;
        o.h = 32'(s_if.O_hcount); o.v = 32'(s_if.O_vcount);
        o.nh = s_if.O_not_hblank; o.nv = s_if.O_not_vblank; o.nb = s_if.O_not_blank;
        o.hs = s_if.O_hsync; o.vs = s_if.O_vsync;
        o.ls = s_if.O_line_start; o.fs = s_if.O_frame_start;
        o.flag = s_if.O_vblank_flag; o.nmi = s_if.O_nmi; o.irq = s_if.O_irq;
        cmp_rec("s", o, e);
      end
    end
  end

  task automatic wait_d_h(input int unsigned h, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (32'(d_if.O_hcount) == h) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Directed stimulus sequence.
  initial begin
    bit ok;
    bit prev;
    int per, hi, cnt;

    rst = 1'b1;
    d_if.I_nmi_enable = 1'b1; d_if.I_status_read = 1'b0; d_if.I_irq_line = 16'd0;
    s_if.I_nmi_enable = 1'b1; s_if.I_status_read = 1'b0; s_if.I_irq_line = 8'd2;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst.d_hcount", 64'(d_if.O_hcount), 64'd0);
    chk("rst.d_clock",  64'(d_if.O_clock),  64'd1);
    chk("rst.d_hsync",  64'(d_if.O_hsync),  64'd1);
    chk("rst.s_hsync",  64'(s_if.O_hsync),  64'd0);
    chk("rst.d_blank",  64'(d_if.O_not_blank), 64'd1);
    rst = 1'b0;

    // First advance lands at the end of cycle P_clock_div-1.
    repeat (4) @(negedge clk);
    chk("first_adv.d_hcount", 64'(d_if.O_hcount), 64'd1);
    chk("first_adv.d_rise",   64'(d_if.O_rise),   64'd0);
    chk("first_adv.s_hcount", 64'(s_if.O_hcount), 64'd2);

    // Vblank flag set at (1, P_v_active+1), NMI one cycle later.
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (s_if.O_vblank_flag) begin ok = 1'b1; break; end
    end
    chk("vbl.seen",   64'(ok), 64'd1);
    chk("vbl.hcount", 64'(s_if.O_hcount), 64'd1);
    chk("vbl.vcount", 64'(s_if.O_vcount), 64'd5);
    chk("vbl.nmi_lag", 64'(s_if.O_nmi), 64'd0);
    @(negedge clk);
    chk("vbl.nmi", 64'(s_if.O_nmi), 64'd1);

    // Host read clears the flag, NMI follows a cycle later.
    s_if.I_status_read = 1'b1;
    @(negedge clk);
    s_if.I_status_read = 1'b0;
    chk("rd.flag", 64'(s_if.O_vblank_flag), 64'd0);
    @(negedge clk);
    chk("rd.nmi", 64'(s_if.O_nmi), 64'd0);

    // Read on the exact set edge suppresses the flag for the whole frame.
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (s_if.O_hcount == 8'd0 && s_if.O_vcount == 8'd5 && s_if.O_rise) begin ok = 1'b1; break; end
    end
    chk("race.found", 64'(ok), 64'd1);
    s_if.I_status_read = 1'b1;
    @(negedge clk);
    s_if.I_status_read = 1'b0;
    chk("race.hcount", 64'(s_if.O_hcount), 64'd1);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      chk("race.flag", 64'(s_if.O_vblank_flag), 64'd0);
      chk("race.nmi",  64'(s_if.O_nmi), 64'd0);
      if (s_if.O_vcount == 8'd7) begin ok = 1'b1; break; end
    end
    chk("race.prerender", 64'(ok), 64'd1);

    // Frame period 16*8*2 = 256 cycles, frame_start high for one pixel.
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (s_if.O_frame_start) begin ok = 1'b1; break; end
    end
    chk("frame.first", 64'(ok), 64'd1);
    ok = 1'b0; per = 0; hi = 1; prev = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      per++;
      if (s_if.O_frame_start && !prev) begin ok = 1'b1; break; end
      if (s_if.O_frame_start) hi++;
      prev = s_if.O_frame_start;
    end
    chk("frame.second", 64'(ok), 64'd1);
    chk("frame.period", 64'(per), 64'd256);
    chk("frame.width",  64'(hi),  64'd2);

    // Default raster: line wrap, blanking and hsync window on line 1.
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (d_if.O_vcount == 16'd1) begin ok = 1'b1; break; end
    end
    chk("dline.seen",   64'(ok), 64'd1);
    chk("dline.hcount", 64'(d_if.O_hcount), 64'd0);
    chk("dline.start",  64'(d_if.O_line_start), 64'd1);
    chk("dline.frame",  64'(d_if.O_frame_start), 64'd0);
    wait_d_h(256, ok);
    chk("dblank.seen", 64'(ok), 64'd1);
    chk("dblank.nb",   64'(d_if.O_not_blank), 64'd0);
    wait_d_h(267, ok);
    chk("dhs_on.seen", 64'(ok), 64'd1);
    chk("dhs_on.hsync", 64'(d_if.O_hsync), 64'd0);
    wait_d_h(291, ok);
    chk("dhs_last.hsync", 64'(d_if.O_hsync), 64'd0);
    wait_d_h(292, ok);
    chk("dhs_off.seen", 64'(ok), 64'd1);
    chk("dhs_off.hsync", 64'(d_if.O_hsync), 64'd1);

    // Mid-frame reset returns everything to reset values immediately.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst.d_hcount", 64'(d_if.O_hcount), 64'd0);
    chk("mrst.d_vcount", 64'(d_if.O_vcount), 64'd0);
    chk("mrst.d_clock",  64'(d_if.O_clock), 64'd1);
    chk("mrst.d_hsync",  64'(d_if.O_hsync), 64'd1);
    chk("mrst.d_nb",     64'(d_if.O_not_blank), 64'd1);
    chk("mrst.s_hsync",  64'(s_if.O_hsync), 64'd0);
    chk("mrst.s_ls",     64'(s_if.O_line_start), 64'd0);
    chk("mrst.s_irq",    64'(s_if.O_irq), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

`ifdef RASTER_IRQ_EN
    // Raster IRQ on line 2 at dot P_h_active; an out-of-range line never fires.
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (s_if.O_irq) begin ok = 1'b1; break; end
    end
    chk("irq.seen",   64'(ok), 64'd1);
    chk("irq.hcount", 64'(s_if.O_hcount), 64'd8);
    chk("irq.vcount", 64'(s_if.O_vcount), 64'd2);
    s_if.I_irq_line = 8'd9;
    repeat (4) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_if.O_irq) cnt++;
    end
    chk("irq.out_of_range", 64'(cnt), 64'd0);
`else
    // Without the raster IRQ the output stays low.
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_if.O_irq || d_if.O_irq) cnt++;
    end
    chk("irq.tied_low", 64'(cnt), 64'd0);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
